// File: rtl/sram_bytewr_clr.sv
// sram_bytewr_clr: single-port synchronous SRAM with per-byte write enables,
// a registered read with a one-cycle valid strobe, and a sequential
// (one word per cycle) array clear after reset or on request.
module sram_bytewr_clr #(
    parameter int  A_WIDTH  = 7,
    parameter int  D_WIDTH  = 32,
    localparam int BE_WIDTH = D_WIDTH / 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                En,
    input  logic                RW,
    input  logic [A_WIDTH-1:0]  Addr,
    input  logic [D_WIDTH-1:0]  Data_In,
    input  logic [BE_WIDTH-1:0] Be,
    input  logic                Clr,
    output logic [D_WIDTH-1:0]  Data_Out,
    output logic                Rd_Valid,
    output logic                Busy
);

    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [A_WIDTH-1:0]   clr_cnt_reg;
    logic [A_WIDTH-1:0]   clr_cnt_next;

    logic                 clearing;
    logic                 access_ok;
    logic                 wr_access;
    logic                 rd_access;

    logic [BE_WIDTH-1:0]  mem_we;
    logic [A_WIDTH-1:0]   mem_addr;
    logic [D_WIDTH-1:0]   mem_wdata;

    logic [D_WIDTH-1:0]   mem [DEPTH];
    logic [D_WIDTH-1:0]   rd_data_reg;
    logic                 out_zero_reg;
    logic                 rd_valid_reg;

    // A clear request in IDLE wins over any access in the same cycle;
    // nothing from the user port reaches the array while clearing.
    assign clearing  = (state_reg == CLEAR);
    assign access_ok = (state_reg == IDLE) && !Clr && En;
    assign wr_access = access_ok && RW;
    assign rd_access = access_ok && !RW;
    assign mem_addr  = clearing ? clr_cnt_reg : Addr;

    // Per-byte lane steering: the clear writes zero to every lane.
    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
            assign mem_we[gi]             = clearing | (wr_access & Be[gi]);
            assign mem_wdata[gi*8 +: 8]   = clearing ? 8'h00 : Data_In[gi*8 +: 8];
        end
    endgenerate

    // FSM state and clear counter; reset restarts the clear from word 0.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Next-state logic: walk the array in CLEAR, accept clear requests in IDLE.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + A_WIDTH'(1);
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (Clr) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    // Array write port with byte lanes and registered read data (no reset,
    // so the array and its output register map onto block RAM).
    always_ff @(posedge Clk) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (mem_we[b]) begin
                mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
        if (rd_access) begin
            rd_data_reg <= mem[Addr];
        end
    end

    // Read strobe and output-zero flag: these carry the asynchronous reset so
    // Data_Out reads as zero immediately on reset and until the first read.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_valid_reg <= 1'b0;
            out_zero_reg <= 1'b1;
        end else begin
            rd_valid_reg <= rd_access;
            if (rd_access) begin
                out_zero_reg <= 1'b0;
            end
        end
    end

    assign Data_Out = out_zero_reg ? '0 : rd_data_reg;
    assign Rd_Valid = rd_valid_reg;
    assign Busy     = clearing;

endmodule

// File: tb/tb_sram_bytewr_clr.sv
// Testbench for sram_bytewr_clr: directed vector table, hand-written
// reset/clear sequences, randomized traffic against a behavioural model,
// and a small-geometry regression instance.
module tb_sram_bytewr_clr;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 128;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          En;
    logic          RW;
    logic [AW-1:0] Addr;
    logic [DW-1:0] Data_In;
    logic [BW-1:0] Be;
    logic          Clr;
    logic [DW-1:0] Data_Out;
    logic          Rd_Valid;
    logic          Busy;

    logic          rst2_n;
    logic          en2;
    logic          rw2;
    logic [3:0]    addr2;
    logic [15:0]   din2;
    logic [1:0]    be2;
    logic          clr2;
    logic [15:0]   dout2;
    logic          rv2;
    logic          busy2;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: whole-word array, remaining clear cycles,
    // expected output data and valid strobe.
    logic [31:0] ref_mem [DEPTH];
    int          clr_left;
    logic [31:0] exp_do;
    logic        exp_rv;

    typedef struct {
        logic        en;
        logic        rw;
        logic [6:0]  addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        clr;
        logic [31:0] exp_do;
        logic        exp_rv;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    sram_bytewr_clr #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .RW(RW), .Addr(Addr),
        .Data_In(Data_In), .Be(Be), .Clr(Clr),
        .Data_Out(Data_Out), .Rd_Valid(Rd_Valid), .Busy(Busy)
    );

    sram_bytewr_clr #(.A_WIDTH(4), .D_WIDTH(16)) dut2 (
        .Clk(Clk), .Rst_n(rst2_n), .En(en2), .RW(rw2), .Addr(addr2),
        .Data_In(din2), .Be(be2), .Clr(clr2),
        .Data_Out(dout2), .Rd_Valid(rv2), .Busy(busy2)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        clr_left = DEPTH;
        exp_do   = '0;
        exp_rv   = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // One clock of the reference: clear in progress swallows everything,
    // a clear request wipes the array, otherwise a byte-masked write or a read.
    task automatic model_step(input logic en, input logic rw, input logic [6:0] a,
                              input logic [31:0] d, input logic [3:0] be, input logic clr);
        if (clr_left > 0) begin
            clr_left--;
            exp_rv = 1'b0;
        end else if (clr) begin
            clr_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            exp_rv = 1'b0;
        end else if (en && rw) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end
            exp_rv = 1'b0;
        end else if (en) begin
            exp_do = ref_mem[a];
            exp_rv = 1'b1;
        end else begin
            exp_rv = 1'b0;
        end
    endtask

    task automatic step(input logic en, input logic rw, input logic [6:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic clr);
        En = en; RW = rw; Addr = a; Data_In = d; Be = be; Clr = clr;
        @(posedge Clk);
        #1;
        model_step(en, rw, a, d, be, clr);
    endtask

    task automatic check_model(input string name);
        chk({name, " data"},  Data_Out,      exp_do);
        chk({name, " valid"}, 32'(Rd_Valid), 32'(exp_rv));
        chk({name, " busy"},  32'(Busy),     32'(clr_left > 0));
    endtask

    // Step until Busy drops (bounded); with noise, issue accesses and Clr
    // pulses that the design must ignore while clearing.
    task automatic wait_clear(input string name, input bit noise);
        int n;
        n = 0;
        do begin
            if (noise)
                step(1'b1, 1'($urandom_range(0, 1)), 7'($urandom), $urandom,
                     4'($urandom), 1'($urandom_range(0, 7) == 0));
            else
                step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            check_model({name, " clearing"});
            n++;
        end while (Busy && n < 300);
        chk({name, " clear length"}, 32'(n), 32'(DEPTH));
        $display("%s: clear finished after %0d cycles", name, n);
    endtask

    function automatic vec_t mk(input logic en, input logic rw, input logic [6:0] a,
                                input logic [31:0] d, input logic [3:0] be, input logic clr,
                                input logic [31:0] xdo, input logic xrv, input logic xbusy);
        vec_t v;
        v.en = en; v.rw = rw; v.addr = a; v.din = d; v.be = be; v.clr = clr;
        v.exp_do = xdo; v.exp_rv = xrv; v.exp_busy = xbusy;
        return v;
    endfunction

    initial begin
        Rst_n = 1'b0; En = 0; RW = 0; Addr = '0; Data_In = '0; Be = '0; Clr = 0;
        rst2_n = 1'b0; en2 = 0; rw2 = 0; addr2 = '0; din2 = '0; be2 = '0; clr2 = 0;

        // Reset values while held in reset.
        repeat (3) @(negedge Clk);
        chk("reset data",  Data_Out,      32'h0);
        chk("reset valid", 32'(Rd_Valid), 32'h0);
        chk("reset busy",  32'(Busy),     32'h1);
        Rst_n = 1'b1;
        model_reset();
        wait_clear("power-up", 1'b0);

        // Directed vector table.
        vecs.push_back(mk(1, 0, 7'h00, 32'h0,        4'h0, 0, 32'h0,        1, 0));
        vecs.push_back(mk(1, 0, 7'h7F, 32'h0,        4'h0, 0, 32'h0,        1, 0));
        vecs.push_back(mk(1, 1, 7'h05, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1, 7'h05, 32'h11223344, 4'h5, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0, 7'h05, 32'h0,        4'h0, 0, 32'hDE22BE44, 1, 0));
        vecs.push_back(mk(0, 0, 7'h00, 32'h0,        4'h0, 0, 32'hDE22BE44, 0, 0));
        vecs.push_back(mk(1, 1, 7'h01, 32'h0000000A, 4'hF, 0, 32'hDE22BE44, 0, 0));
        vecs.push_back(mk(1, 1, 7'h02, 32'h0000000B, 4'hF, 0, 32'hDE22BE44, 0, 0));
        vecs.push_back(mk(1, 1, 7'h03, 32'h0000000C, 4'hF, 0, 32'hDE22BE44, 0, 0));
        vecs.push_back(mk(1, 0, 7'h01, 32'h0,        4'h0, 0, 32'h0000000A, 1, 0));
        vecs.push_back(mk(1, 0, 7'h02, 32'h0,        4'h0, 0, 32'h0000000B, 1, 0));
        vecs.push_back(mk(1, 0, 7'h03, 32'h0,        4'h0, 0, 32'h0000000C, 1, 0));
        vecs.push_back(mk(0, 0, 7'h00, 32'h0,        4'h0, 0, 32'h0000000C, 0, 0));
        vecs.push_back(mk(1, 1, 7'h03, 32'hFFFFFFFF, 4'h0, 0, 32'h0000000C, 0, 0));
        vecs.push_back(mk(1, 0, 7'h03, 32'h0,        4'h0, 0, 32'h0000000C, 1, 0));
        vecs.push_back(mk(1, 1, 7'h7F, 32'hA5A5A555, 4'h1, 0, 32'h0000000C, 0, 0));
        vecs.push_back(mk(1, 0, 7'h7F, 32'h0,        4'h0, 0, 32'h00000055, 1, 0));
        vecs.push_back(mk(1, 1, 7'h40, 32'hCAFEF00D, 4'hA, 0, 32'h00000055, 0, 0));
        vecs.push_back(mk(1, 0, 7'h40, 32'h0,        4'h0, 0, 32'hCA00F000, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].be, vecs[i].clr);
            chk($sformatf("vec%0d data", i),  Data_Out,      vecs[i].exp_do);
            chk($sformatf("vec%0d valid", i), 32'(Rd_Valid), 32'(vecs[i].exp_rv));
            chk($sformatf("vec%0d busy", i),  32'(Busy),     32'(vecs[i].exp_busy));
            $display("vec%0d en=%0b rw=%0b addr=%h din=%h be=%h -> dout=%h rv=%0b busy=%0b",
                     i, vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].be,
                     Data_Out, Rd_Valid, Busy);
        end

        // Clear request collides with a write: write dropped, accesses ignored.
        step(1'b1, 1'b1, 7'h10, 32'h12345678, 4'hF, 1'b1);
        check_model("clr+write");
        wait_clear("clr+write", 1'b1);
        step(1'b1, 1'b0, 7'h10, '0, '0, 1'b0);
        check_model("read after clear");
        chk("read 0x10 after clear", Data_Out, 32'h0);
        $display("read 0x10 after clear -> dout=%h rv=%0b", Data_Out, Rd_Valid);

        // Reset at clear cycle 40 with a non-zero Data_Out held.
        step(1'b1, 1'b1, 7'h20, 32'h0BADF00D, 4'hF, 1'b0);
        step(1'b1, 1'b0, 7'h20, '0, '0, 1'b0);
        check_model("preload read");
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check_model("clear start");
        for (int i = 1; i < 40; i++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            check_model("pre-reset clear");
        end
        #2 Rst_n = 1'b0;
        #1;
        chk("mid-clear reset data",  Data_Out,      32'h0);
        chk("mid-clear reset valid", 32'(Rd_Valid), 32'h0);
        chk("mid-clear reset busy",  32'(Busy),     32'h1);
        $display("reset at clear cycle 40 -> dout=%h rv=%0b busy=%0b", Data_Out, Rd_Valid, Busy);
        @(negedge Clk); @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        wait_clear("after mid-clear reset", 1'b0);

        // Reset while a read result is being presented.
        step(1'b1, 1'b1, 7'h21, 32'h00000077, 4'hF, 1'b0);
        step(1'b1, 1'b0, 7'h21, '0, '0, 1'b0);
        check_model("pre-reset read");
        #1 Rst_n = 1'b0;
        #1;
        chk("mid-read reset valid", 32'(Rd_Valid), 32'h0);
        chk("mid-read reset data",  Data_Out,      32'h0);
        $display("reset during read valid -> dout=%h rv=%0b", Data_Out, Rd_Valid);
        @(negedge Clk); @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        wait_clear("after mid-read reset", 1'b0);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 600; t++) begin
            logic        r_en, r_rw, r_clr;
            logic [6:0]  r_a;
            logic [31:0] r_d;
            logic [3:0]  r_be;
            r_clr = ($urandom_range(0, 149) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_rw  = 1'($urandom_range(0, 1));
            r_a   = ($urandom_range(0, 3) != 0) ? 7'($urandom_range(0, 15)) : 7'($urandom);
            r_d   = $urandom;
            r_be  = 4'($urandom);
            step(r_en, r_rw, r_a, r_d, r_be, r_clr);
            check_model($sformatf("rand%0d", t));
            if (r_en || r_clr)
                $display("rand%0d en=%0b rw=%0b clr=%0b addr=%h din=%h be=%h -> dout=%h rv=%0b busy=%0b",
                         t, r_en, r_rw, r_clr, r_a, r_d, r_be, Data_Out, Rd_Valid, Busy);
        end
        En = 0; Clr = 0;

        // Small-geometry regression: 16-word clear, upper-byte-only write.
        @(negedge Clk);
        chk("small reset busy", 32'(busy2), 32'h1);
        rst2_n = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(posedge Clk); #1;
                n++;
            end while (busy2 && n < 100);
            chk("small clear length", 32'(n), 32'd16);
            $display("small instance: clear finished after %0d cycles", n);
        end
        en2 = 1; rw2 = 1; addr2 = 4'h3; din2 = 16'hABCD; be2 = 2'b10;
        @(posedge Clk); #1;
        chk("small write valid", 32'(rv2), 32'h0);
        en2 = 1; rw2 = 0; be2 = 2'b00; din2 = '0;
        @(posedge Clk); #1;
        chk("small read data",  32'(dout2), 32'h0000AB00);
        chk("small read valid", 32'(rv2),   32'h1);
        $display("small instance: be=10 write ABCD then read -> dout=%h rv=%0b", dout2, rv2);
        en2 = 0;
        @(posedge Clk); #1;
        chk("small valid drop", 32'(rv2),   32'h0);
        chk("small data hold",  32'(dout2), 32'h0000AB00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
